sevenseg_mux: RTL

Parametrised, time-multiplexed driver for a bank of common-anode/cathode seven-segment digits. It replaces the single-digit combinational decoder: it latches a packed hex word and decodes the full 0–F range. It scans one digit at a time at a programmable refresh rate, with per-digit decimal point, per-digit blanking and optional leading-zero suppression. It sits between the datapath (e.g. a counter or register value) and the board's anode/segment pins.

---
 rtl/sevenseg_mux.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sevenseg_mux.sv
// Time-multiplexed seven-segment driver: latches a packed hex word, scans one
// digit per REFRESH_DIV cycles, with per-digit dp, blanking and leading-zero suppression.
module sevenseg_mux #(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          load_i,
    input  logic [4*NDIGITS-1:0]                          data_i,
    input  logic [NDIGITS-1:0]                            dp_in_i,
    input  logic [NDIGITS-1:0]                            blank_i,
    output logic [NDIGITS-1:0]                            anode_o,
    output logic [6:0]                                    segments_o,
    output logic                                          dp_o,
    output logic [((NDIGITS > 1) ? $clog2(NDIGITS) : 1)-1:0] digit_idx_o
);

    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [NDIGITS-1:0] AN_OFF  = {NDIGITS{POL}};
    localparam logic [6:0]         SEG_OFF = {7{POL}};

    // active-high abcdefg pattern for one hex nibble
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    logic [4*NDIGITS-1:0] data_q, data_d;
    logic [NDIGITS-1:0]   dp_q, dp_d;
    logic [NDIGITS-1:0]   blank_q, blank_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NDIGITS-1:0]   anode_q, anode_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dpo_q, dpo_d;
    logic [IDX_W-1:0]     didx_q;

    logic                 cnt_last;
    logic [NDIGITS-1:0]   dark;
    logic [NDIGITS-1:0]   an_act;
    logic [6:0]           seg_act;
    logic                 dp_act;
    logic [3:0]           nib;

    // Dark flags come from the shadow registers, so a digit's suppression
    // always matches the value it would have shown.
    for (genvar k = 0; k < NDIGITS; k++) begin : g_dark
        if (k == 0 || LZ_SUPPRESS == 0) begin : g_plain
            assign dark[k] = blank_q[k];
        end else begin : g_lz
            assign dark[k] = blank_q[k] | (data_q[4*NDIGITS-1:4*k] == '0);
        end
    end

    always_comb begin
        data_d  = data_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        if (load_i) begin
            data_d  = data_i;
            dp_d    = dp_in_i;
            blank_d = blank_i;
        end
    end

    assign cnt_last = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_last) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        nib     = data_q[4*idx_q +: 4];
        an_act  = '0;
        seg_act = '0;
        dp_act  = 1'b0;
        if (!dark[idx_q]) begin
            an_act[idx_q] = 1'b1;
            seg_act       = seg_decode(nib);
            dp_act        = dp_q[idx_q];
        end
        anode_d = an_act ^ AN_OFF;
        seg_d   = seg_act ^ SEG_OFF;
        dpo_d   = dp_act ^ POL;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            anode_q <= AN_OFF;
            seg_q   <= SEG_OFF;
            dpo_q   <= POL;
            didx_q  <= '0;
        end else begin
            data_q  <= data_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
            didx_q  <= idx_q;
        end
    end

    assign anode_o     = anode_q;
    assign segments_o  = seg_q;
    assign dp_o        = dpo_q;
    assign digit_idx_o = didx_q;

endmodule
